// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and character width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous level; resets to 1 (idle line).
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '1;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling and ready/clear handshake.
// Define UART_RX_PARITY_EN to add a parity bit (sense set by PARITY_ODD).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic                      clk_50m,
  input  logic                      rst_n,
  input  logic                      rx,
  input  logic                      clken,
  input  logic                      rdy_clr,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      rdy,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      parity_err
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [SW-1:0] MID_TICK  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] LAST_TICK = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  uart_rx_state_t            state, state_n;
  logic [SW-1:0]             sample, sample_n;
  logic [BW-1:0]             bitpos, bitpos_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic [UART_DATA_BITS-1:0] data_n;
  logic                      rdy_n, frame_err_n, overrun_n;
`ifdef UART_RX_PARITY_EN
  logic                      par_bit, par_bit_n, parity_err_n;
`endif

  always_comb begin
    state_n     = state;
    sample_n    = sample;
    bitpos_n    = bitpos;
    shift_n     = shift;
    data_n      = data;
    rdy_n       = rdy & ~rdy_clr;
    overrun_n   = overrun & ~rdy_clr;
    frame_err_n = frame_err;
`ifdef UART_RX_PARITY_EN
    par_bit_n    = par_bit;
    parity_err_n = parity_err;
`endif
    if (clken) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n  = START;
            sample_n = '0;
          end
        end
        START: begin
          if (rx_s) begin
            state_n = IDLE;
          end else if (sample == MID_TICK) begin
            state_n  = DATA;
            sample_n = '0;
            bitpos_n = '0;
          end else begin
            sample_n = sample + 1'b1;
          end
        end
        DATA: begin
          if (sample == LAST_TICK) begin
            sample_n        = '0;
            shift_n[bitpos] = rx_s;
            if (bitpos == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              bitpos_n = bitpos + 1'b1;
            end
          end else begin
            sample_n = sample + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample == LAST_TICK) begin
            sample_n  = '0;
            par_bit_n = rx_s;
            state_n   = STOP;
          end else begin
            sample_n = sample + 1'b1;
          end
        end
`endif
        STOP: begin
          if (sample == LAST_TICK) begin
            sample_n = '0;
            state_n  = IDLE;
            // A completing byte overrides a same-cycle rdy_clr; overrun reflects the old rdy.
            if (rx_s) begin
              data_n      = shift;
              rdy_n       = 1'b1;
              overrun_n   = overrun_n | rdy;
              frame_err_n = 1'b0;
            end else begin
              frame_err_n = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            parity_err_n = (^shift) ^ par_bit ^ PARITY_ODD;
`endif
          end else begin
            sample_n = sample + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sample    <= '0;
      bitpos    <= '0;
      shift     <= '0;
      data      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      sample    <= sample_n;
      bitpos    <= bitpos_n;
      shift     <= shift_n;
      data      <= data_n;
      rdy       <= rdy_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bit    <= par_bit_n;
      parity_err <= parity_err_n;
    end
  end
`else
  // Parity sense is irrelevant without a parity bit.
  assign parity_err = 1'b0 & PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed vector table, timed corner
// cases, and randomized frames against a frame-level reference model.
module tb_uart_receiver;

  localparam int OS       = 16;
  localparam int SYNC     = 2;
  localparam bit PAR_ODD  = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit PAR_ON     = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit PAR_ON     = 1'b0;
`endif
  // Edges from the first low tick to rdy: mid-stop point plus synchronizer.
  localparam int LAT = FRAME_BITS*OS - OS/2 + SYNC;

  typedef enum int {OP_FRAME, OP_CLR, OP_GLITCH} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] b;
    logic       stop;
    logic [7:0] e_data;
    logic       e_rdy;
    logic       e_fe;
    logic       e_ovr;
  } vec_t;

  logic       clk_50m = 1'b0;
  logic       rst_n, rx, clken, rdy_clr;
  logic [7:0] data;
  logic       rdy, frame_err, overrun, parity_err;

  int errors = 0;
  int checks = 0;
  int gap    = 0;
  logic fb[$];
  logic [7:0] m_data;
  logic m_rdy, m_fe, m_ovr, m_pe;
  vec_t vecs[14];

  uart_receiver #(
    .OVERSAMPLE  (OS),
    .SYNC_STAGES (SYNC),
    .PARITY_ODD  (PAR_ODD)
  ) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .rx         (rx),
    .clken      (clken),
    .rdy_clr    (rdy_clr),
    .data       (data),
    .rdy        (rdy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #10 clk_50m = ~clk_50m;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, want %02h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_data, input logic e_rdy,
                         input logic e_fe, input logic e_ovr, input logic e_pe);
    chk({tag, ".data"},       data,                {e_data});
    chk({tag, ".rdy"},        {7'd0, rdy},         {7'd0, e_rdy});
    chk({tag, ".frame_err"},  {7'd0, frame_err},   {7'd0, e_fe});
    chk({tag, ".overrun"},    {7'd0, overrun},     {7'd0, e_ovr});
    chk({tag, ".parity_err"}, {7'd0, parity_err},  {7'd0, e_pe});
  endtask

  // One oversample tick: clken high for one cycle, then gap idle cycles.
  task automatic tick(input logic r);
    rx    = r;
    clken = 1'b1;
    @(negedge clk_50m);
    clken = 1'b0;
    repeat (gap) @(negedge clk_50m);
  endtask

  // Bad stop bits stay low only long enough to be sampled, so the line
  // returns high before a new start could be qualified.
  task automatic build_frame(input logic [7:0] b, input logic stop, input logic pflip);
    fb.delete();
    repeat (OS) fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (OS) fb.push_back(b[i]);
    if (PAR_ON) repeat (OS) fb.push_back((^b) ^ PAR_ODD ^ pflip);
    if (stop) repeat (OS) fb.push_back(1'b1);
    else begin
      repeat (10) fb.push_back(1'b0);
      repeat (OS-10) fb.push_back(1'b1);
    end
    repeat (4) fb.push_back(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pflip);
    build_frame(b, stop, pflip);
    foreach (fb[i]) tick(fb[i]);
  endtask

  task automatic send_timed(input logic [7:0] b, input int clr_at, output int lat);
    build_frame(b, 1'b1, 1'b0);
    lat = -1;
    for (int t = 0; t < fb.size(); t++) begin
      rx      = fb[t];
      clken   = 1'b1;
      rdy_clr = (t == clr_at);
      @(negedge clk_50m);
      rdy_clr = 1'b0;
      if (lat < 0 && rdy === 1'b1) lat = t;
    end
    clken = 1'b0;
  endtask

  task automatic clr_pulse();
    rx      = 1'b1;
    clken   = 1'b1;
    rdy_clr = 1'b1;
    @(negedge clk_50m);
    rdy_clr = 1'b0;
    clken   = 1'b0;
    repeat (gap) @(negedge clk_50m);
  endtask

  task automatic glitch(input int n);
    repeat (n) tick(1'b0);
    repeat (OS) tick(1'b1);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop, input logic pflip);
    if (stop) begin
      m_ovr  = m_ovr | m_rdy;
      m_data = b;
      m_rdy  = 1'b1;
      m_fe   = 1'b0;
    end else begin
      m_fe = 1'b1;
    end
    if (PAR_ON) m_pe = pflip;
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_rdy = 1'b0; m_fe = 1'b0; m_ovr = 1'b0; m_pe = 1'b0;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; rx = 1'b1; clken = 1'b0; rdy_clr = 1'b0;

    vecs[0]  = '{OP_FRAME,  8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{OP_CLR,    8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{OP_GLITCH, 8'd6,  1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{OP_FRAME,  8'h3C, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{OP_FRAME,  8'h81, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{OP_CLR,    8'h00, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_FRAME,  8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{OP_FRAME,  8'h22, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{OP_CLR,    8'h00, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_FRAME,  8'h3C, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{OP_GLITCH, 8'd7,  1'b1, 8'h22, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{OP_FRAME,  8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{OP_FRAME,  8'hFF, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{OP_FRAME,  8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge clk_50m);
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50m);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_FRAME:  send_frame(vecs[i].b, vecs[i].stop, 1'b0);
        OP_CLR:    clr_pulse();
        default:   glitch(int'(vecs[i].b));
      endcase
      chk_out($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_rdy, vecs[i].e_fe,
              vecs[i].e_ovr, 1'b0);
    end

    clr_pulse();
    chk_out("clr_ovr", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    send_timed(8'h96, -1, lat);
    chk("latency", lat[7:0], 8'(LAT));
    chk_out("lat_frame", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
    send_timed(8'h69, LAT, lat);
    chk_out("clr_same_cycle_rdy1", 8'h69, 1'b1, 1'b0, 1'b1, 1'b0);
    clr_pulse();
    chk_out("clr2", 8'h69, 1'b0, 1'b0, 1'b0, 1'b0);
    send_timed(8'hC3, LAT, lat);
    chk_out("clr_same_cycle_rdy0", 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    clr_pulse();
    send_frame(8'h07, 1'b1, 1'b1);
    chk_out("par_bad", 8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
    clr_pulse();
    send_frame(8'h07, 1'b1, 1'b0);
    chk_out("par_good", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    // Reset in the middle of data bit 4 while a byte is pending.
    build_frame(8'h5A, 1'b1, 1'b0);
    for (int t = 0; t < OS + 4*OS + OS/2; t++) tick(fb[t]);
    rst_n = 1'b0;
    #1;
    chk_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick(1'b1);
    rst_n = 1'b1;
    repeat (OS) tick(1'b1);
    chk_out("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    chk_out("post_reset_frame", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

    clr_pulse();
    repeat (3*FRAME_BITS*OS) tick(1'b0);
    chk_out("break", 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) tick(1'b1);
    rst_n = 1'b1;
    repeat (OS) tick(1'b1);
    chk_out("break_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    model_reset();
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic stop, pflip;
      gap = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        clr_pulse();
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) glitch(int'($urandom_range(1, 7)));
      b     = 8'($urandom);
      stop  = ($urandom_range(0, 7) != 0);
      pflip = PAR_ON && ($urandom_range(0, 3) == 0);
      send_frame(b, stop, pflip);
      model_frame(b, stop, pflip);
      chk_out($sformatf("rand%0d", n), m_data, m_rdy, m_fe, m_ovr, m_pe);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
8N1 UART receiver, the receive-side counterpart of the team's uart_transmitter. It is clocked by clk_50m and advanced by a clken tick at OVERSAMPLE times the baud rate, supplied by the shared baud generator. It samples the serial line at mid-bit, assembles the byte LSB-first, and presents it to the bus side with a ready/clear handshake. It also reports framing and overrun errors.

Parameters:
OVERSAMPLE, 16, clken ticks per bit; power of two, minimum 4; mid-bit point is OVERSAMPLE/2.
SYNC_STAGES, 2, flops in the rx input synchronizer; minimum 2.
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
clk_50m  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous, active-low reset.
rx  input  1  serial line, asynchronous, idle high.
clken  input  1  oversample tick, one clk_50m cycle wide.
rdy_clr  input  1  consumer acknowledge; clears rdy and overrun.
data  output  8  last received byte; valid while rdy=1.
rdy  output  1  byte available.
frame_err  output  1  stop bit of the last frame was 0.
overrun  output  1  a byte completed while rdy was already 1 (sticky).
parity_err  output  1  parity mismatch on the last frame; constant 0 without the macro.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all synchronizer flops=1; sample counter=0; bitpos=0; shift register=0.
  - Outputs: data=8'h00, rdy=0, frame_err=0, overrun=0, parity_err=0.
- rx passes through SYNC_STAGES flops; rx_s is the last stage. All decisions use rx_s and act only on cycles with clken=1.
- States: IDLE, START, DATA, STOP (plus PARITY with the macro).
- IDLE:
  - rx_s=0 -> START, with sample=0.
- START:
  - rx_s=1 -> IDLE. A low pulse shorter than the mid-bit point is rejected as a glitch.
  - Otherwise sample++.
  - When sample reaches OVERSAMPLE/2-1 with rx_s=0 -> DATA, with sample=0 and bitpos=0.
- DATA:
  - sample++ each tick.
  - At sample=OVERSAMPLE-1: shift[bitpos]<=rx_s, sample<=0.
  - bitpos=7 -> STOP; otherwise bitpos++.
- STOP:
  - Sample at sample=OVERSAMPLE-1, then -> IDLE.
  - rx_s=1: data<=shift, rdy<=1, frame_err<=0.
  - rx_s=0: frame_err<=1; data and rdy unchanged; the byte is discarded.
- Line held low (break): each frame ends in a framing error and IDLE immediately restarts on the still-low line. Repeated frame_err is the required behaviour.
- Latency: rdy rises on the clk_50m edge after the clken tick that samples mid-stop. That edge is (9.5*OVERSAMPLE) ticks after the first low tick, plus SYNC_STAGES cycles of synchronizer delay.
- Handshake:
  - rdy stays high until rdy_clr=1, which clears rdy and overrun on the next edge.
  - If a byte completes while rdy=1: data is overwritten and overrun<=1.
  - If a byte completes in the same cycle as rdy_clr: completion wins. rdy stays 1 with the new data, and overrun follows the previous rdy value.
- frame_err and parity_err update only at frame end and hold until the next frame end. rdy_clr does not clear them.
- clken=0: all state, counters and outputs hold.
- Reset mid-frame: the frame is abandoned, no rdy is raised, and the block returns to IDLE.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - PARITY state inserted between DATA and STOP; one parity bit sampled at mid-bit.
  - parity_err<=(XOR of shift and the parity bit) != PARITY_ODD, updated when the stop bit is sampled.
  - The byte is still delivered on a parity error if the stop bit is good.
  - Frame is 11 bits.
- Undefined:
  - 8N1 only; parity_err tied to 0; no PARITY state.

Decomposition:
- Package uart_pkg:
  - uart_rx_state_t enum: IDLE, START, DATA, STOP, PARITY.
  - UART_DATA_BITS=8.
  - Shared with the transmitter when it is ported.
- Sub-module uart_sync: SYNC_STAGES-deep bit synchronizer with asynchronous active-low reset to 1.

Test Plan:
- clken=1 every cycle, OVERSAMPLE=16; send 8'hA5 (8N1) -> rdy=1 with data=8'hA5, frame_err=0. rdy_clr pulse -> rdy=0 on the next edge.
- rx low for 6 ticks then high -> returns to IDLE, rdy stays 0, frame_err unchanged.
- Send 8'h3C with stop bit 0 -> frame_err=1, rdy=0, data keeps its prior value. Then a good 8'h81 -> data=8'h81, rdy=1, frame_err=0.
- Send 8'h11 then 8'h22 without rdy_clr -> data=8'h22, overrun=1. rdy_clr -> rdy=0, overrun=0.
- Assert rst_n=0 at bit 4 of a frame -> all outputs reset immediately. After release, a clean 8'h5A is received correctly.
- With UART_RX_PARITY_EN, PARITY_ODD=0: send 8'h07 with parity bit 0 -> parity_err=1, rdy=1, data=8'h07. Send 8'h07 with parity bit 1 -> parity_err=0.
